// File: rtl/mandelbrot_tile_feeder.sv
// Splits a Mandelbrot tile job into pixel clusters of 8<<shift pixels and
// streams per-cluster coordinate vectors to round-robin downstream feeders.
module mandelbrot_tile_feeder #(
    parameter int COORD_W   = 32,
    parameter int ITER_W    = 16,
    parameter int DIM_W     = 16,
    parameter int ADDR_W    = 32,
    parameter int MAX_SHIFT = 3,
    parameter int NUM_CH    = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IN_W     = 2*DIM_W + ADDR_W + 8 + 3*COORD_W + ITER_W,
    localparam int OUT_W    = CH_W + DIM_W + ADDR_W + 8 + 3*COORD_W + ITER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_vector_snk_data,
    input  logic             in_vector_snk_valid,
    output logic             in_vector_snk_ready,
    output logic [OUT_W-1:0] out_vector_src_data,
    output logic             out_vector_src_valid,
    input  logic             out_vector_src_ready,
    input  logic             abort,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_t;

    state_t              state;
    logic [DIM_W-1:0]    height_q, width_q, x_q, y_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [2:0]          shift_q;
    logic [COORD_W-1:0]  step_q, cr_q, ci_q, leftmost_cr_q;
    logic [ITER_W-1:0]   iters_q;
    logic [CH_W-1:0]     chan_q;

    logic [DIM_W-1:0]    in_height, in_width;
    logic [ADDR_W-1:0]   in_ptr;
    logic [7:0]          in_shift;
    logic [COORD_W-1:0]  in_step, in_cr, in_ci;
    logic [ITER_W-1:0]   in_iters;

    assign {in_height, in_width, in_ptr, in_shift, in_step, in_iters, in_cr, in_ci} =
        in_vector_snk_data;

    logic [2:0]          shift_sel;
    logic [DIM_W:0]      cluster_size, remaining, pix, x_next;
    logic [DIM_W-1:0]    pix_count;
    logic                row_end, last_row;
    logic [COORD_W-1:0]  cr_step;
    logic [ADDR_W-1:0]   ptr_inc;
    logic [7:0]          line_count;
    logic [CH_W-1:0]     chan_next;

    assign shift_sel = (in_shift > 8'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : in_shift[2:0];

    // All dimension arithmetic is one bit wider so a full-range width never wraps.
    assign cluster_size = (DIM_W+1)'(8) << shift_q;
    assign remaining    = {1'b0, width_q} - {1'b0, x_q};
    assign pix          = (remaining > cluster_size) ? cluster_size : remaining;
    assign pix_count    = pix[DIM_W-1:0];
    assign x_next       = {1'b0, x_q} + pix;
    assign row_end      = x_next >= {1'b0, width_q};
    assign last_row     = ({1'b0, y_q} + (DIM_W+1)'(1)) >= {1'b0, height_q};
    assign cr_step      = step_q << (4'd3 + {1'b0, shift_q});
    assign ptr_inc      = ADDR_W'(pix) << 2;
    assign line_count   = 8'd1 << shift_q;
    assign chan_next    = (chan_q == CH_W'(NUM_CH - 1)) ? '0 : chan_q + CH_W'(1);

    assign in_vector_snk_ready  = (state == StIdle);
    assign out_vector_src_valid = (state == StFeed);
    assign busy                 = (state != StIdle);
    assign out_vector_src_data  =
        {chan_q, pix_count, ptr_q, line_count, step_q, iters_q, cr_q, ci_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            done          <= 1'b0;
            height_q      <= '0;
            width_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            ptr_q         <= '0;
            shift_q       <= '0;
            step_q        <= '0;
            cr_q          <= '0;
            ci_q          <= '0;
            leftmost_cr_q <= '0;
            iters_q       <= '0;
            chan_q        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_vector_snk_valid) begin
                        height_q      <= in_height;
                        width_q       <= in_width;
                        ptr_q         <= in_ptr;
                        shift_q       <= shift_sel;
                        step_q        <= in_step;
                        iters_q       <= in_iters;
                        cr_q          <= in_cr;
                        ci_q          <= in_ci;
                        leftmost_cr_q <= in_cr;
                        x_q           <= '0;
                        y_q           <= '0;
                        chan_q        <= '0;
                        // Empty images complete immediately without emitting clusters.
                        if (in_width == '0 || in_height == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= StFeed;
                        end
                    end
                end
                StFeed: begin
                    if (abort) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end else if (out_vector_src_ready) begin
                        ptr_q  <= ptr_q + ptr_inc;
                        chan_q <= chan_next;
                        if (!row_end) begin
                            x_q  <= x_next[DIM_W-1:0];
                            cr_q <= cr_q + cr_step;
                        end else if (!last_row) begin
                            y_q  <= y_q + DIM_W'(1);
                            x_q  <= '0;
                            cr_q <= leftmost_cr_q;
                            ci_q <= ci_q - step_q;
                        end else begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (abort || out_vector_src_ready) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
